// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage; slave is the EX side,
// master is whatever drives ID/EX and consumes EX/MEM (pipeline regs or bench).
interface ex_stage_if;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] link_address_i;
  logic        is_in_delayslot_i;
  logic [31:0] inst_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;

  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [7:0]  aluop_o;
  logic [31:0] mem_addr_o;
  logic [31:0] reg2_o;
  logic        is_in_delayslot_o;
  logic        stallreq_o;

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, link_address_i,
           is_in_delayslot_i, inst_i, hi_i, lo_i,
    output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, aluop_o, mem_addr_o,
           reg2_o, is_in_delayslot_o, stallreq_o
  );

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, link_address_i,
           is_in_delayslot_i, inst_i, hi_i, lo_i,
    input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, aluop_o, mem_addr_o,
           reg2_o, is_in_delayslot_o, stallreq_o
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: zero-latency ALU/move/link results and load/store addressing.
// EX_DIV_EN builds a 32-step restoring divider that stalls the pipeline; otherwise DIV/DIVU yield 0.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input logic         clk,
  input logic         rst,
  ex_stage_if.slave   ex
);
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO = 8'b0001_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [2:0] SEL_JUMP_BRANCH = 3'b110;

  logic [31:0] add_res, sub_res;
  logic        add_ovf, sub_ovf, div_op, div_signed;
  logic [4:0]  shamt;

  assign add_res    = ex.reg1_i + ex.reg2_i;
  assign sub_res    = ex.reg1_i - ex.reg2_i;
  assign add_ovf    = (ex.reg1_i[31] == ex.reg2_i[31]) && (add_res[31] != ex.reg1_i[31]);
  assign sub_ovf    = (ex.reg1_i[31] != ex.reg2_i[31]) && (sub_res[31] != ex.reg1_i[31]);
  assign shamt      = ex.reg1_i[4:0];
  assign div_op     = (ex.aluop_i == OP_DIV) || (ex.aluop_i == OP_DIVU);
  assign div_signed = (ex.aluop_i == OP_DIV);

  logic        div_done, div_stall;
  logic [31:0] div_q, div_r;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t  state;
  logic [5:0]  cnt;
  logic [31:0] dvs;
  logic [63:0] acc;            // {partial remainder, dividend shifting into quotient}
  logic        neg_q, neg_r;
  logic [32:0] rem_sh, rem_sub;
  logic        rem_ge;
  logic [63:0] acc_next;
  logic [31:0] a_abs, b_abs;

  assign a_abs    = (div_signed && ex.reg1_i[31]) ? -ex.reg1_i : ex.reg1_i;
  assign b_abs    = (div_signed && ex.reg2_i[31]) ? -ex.reg2_i : ex.reg2_i;
  // 33-bit partial remainder: an unsigned divisor above 2^31 can push it past 32 bits
  assign rem_sh   = acc[63:31];
  assign rem_sub  = rem_sh - {1'b0, dvs};
  assign rem_ge   = (rem_sh >= {1'b0, dvs});
  assign acc_next = rem_ge ? {rem_sub[31:0], acc[30:0], 1'b1}
                           : {rem_sh[31:0],  acc[30:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dvs   <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div_q <= '0;
      div_r <= '0;
    end else begin
      case (state)
        IDLE: if (div_op) begin
          if (ex.reg2_i == 32'd0) begin
            div_q <= '0;
            div_r <= '0;
            state <= DONE;
          end else begin
            dvs   <= b_abs;
            acc   <= {32'd0, a_abs};
            neg_q <= div_signed && (ex.reg1_i[31] ^ ex.reg2_i[31]);
            neg_r <= div_signed && ex.reg1_i[31];
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(DIV_CYCLES - 1)) begin
            div_q <= neg_q ? -acc_next[31:0]  : acc_next[31:0];
            div_r <= neg_r ? -acc_next[63:32] : acc_next[63:32];
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign div_done  = (state == DONE);
  assign div_stall = div_op && (state != DONE);
`else
  localparam int unused_div_cycles = DIV_CYCLES;
  logic unused_clk;
  assign unused_clk = clk ^ div_signed;
  assign div_done   = 1'b1;
  assign div_stall  = 1'b0;
  assign div_q      = '0;
  assign div_r      = '0;
`endif

  logic [31:0] wdata, hi, lo;
  logic        wreg, whilo;

  always_comb begin
    wdata = '0;
    wreg  = ex.wreg_i;
    whilo = 1'b0;
    hi    = '0;
    lo    = '0;
    case (ex.aluop_i)
      OP_AND:  wdata = ex.reg1_i & ex.reg2_i;
      OP_OR:   wdata = ex.reg1_i | ex.reg2_i;
      OP_XOR:  wdata = ex.reg1_i ^ ex.reg2_i;
      OP_NOR:  wdata = ~(ex.reg1_i | ex.reg2_i);
      OP_SLL:  wdata = ex.reg2_i << shamt;
      OP_SRL:  wdata = ex.reg2_i >> shamt;
      OP_SRA:  wdata = 32'($signed(ex.reg2_i) >>> shamt);
      OP_SLT:  wdata = {31'd0, $signed(ex.reg1_i) < $signed(ex.reg2_i)};
      OP_SLTU: wdata = {31'd0, ex.reg1_i < ex.reg2_i};
      OP_ADDU: wdata = add_res;
      OP_SUBU: wdata = sub_res;
      OP_ADD: begin
        wdata = add_res;
        if (add_ovf) wreg = 1'b0;
      end
      OP_SUB: begin
        wdata = sub_res;
        if (sub_ovf) wreg = 1'b0;
      end
      OP_MFHI: wdata = ex.hi_i;
      OP_MFLO: wdata = ex.lo_i;
      OP_MTHI: begin
        whilo = 1'b1;
        hi    = ex.reg1_i;
        lo    = ex.lo_i;
      end
      OP_MTLO: begin
        whilo = 1'b1;
        hi    = ex.hi_i;
        lo    = ex.reg1_i;
      end
      OP_DIV, OP_DIVU: begin
        whilo = div_done;
        hi    = div_done ? div_r : 32'd0;
        lo    = div_done ? div_q : 32'd0;
      end
      default: ;
    endcase
    if (ex.alusel_i == SEL_JUMP_BRANCH) wdata = ex.link_address_i;
  end

  logic unused_inst;
  assign unused_inst = ^ex.inst_i[31:16];

  assign ex.wd_o              = rst ? 5'd0  : ex.wd_i;
  assign ex.wreg_o            = rst ? 1'b0  : wreg;
  assign ex.wdata_o           = rst ? 32'd0 : wdata;
  assign ex.whilo_o           = rst ? 1'b0  : whilo;
  assign ex.hi_o              = rst ? 32'd0 : hi;
  assign ex.lo_o              = rst ? 32'd0 : lo;
  assign ex.aluop_o           = rst ? 8'd0  : ex.aluop_i;
  assign ex.mem_addr_o        = rst ? 32'd0 : ex.reg1_i + {{16{ex.inst_i[15]}}, ex.inst_i[15:0]};
  assign ex.reg2_o            = rst ? 32'd0 : ex.reg2_i;
  assign ex.is_in_delayslot_o = rst ? 1'b0  : ex.is_in_delayslot_i;
  assign ex.stallreq_o        = rst ? 1'b0  : div_stall;
endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage; divider expectations follow whether EX_DIV_EN is defined.
module tb_ex_stage;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO = 8'b0001_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;
  localparam logic [7:0] OP_JAL  = 8'b0101_0000;
  localparam logic [7:0] OP_LW   = 8'b1110_0011;
  localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010,
                         SEL_MOVE = 3'b011, SEL_ARITH = 3'b100, SEL_JB = 3'b110,
                         SEL_LS = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .ex(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction just after a rising edge, then move to the sampling edge.
  task automatic issue(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2);
    @(posedge clk);
    #1;
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    @(negedge clk);
  endtask

  // Counts stall cycles for a divide already driven, then checks the result cycle.
  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int n;
    issue(op, SEL_NOP, a, b);
    n = 0;
    while (bus.stallreq_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " stall"}, n, exp_stall);
    check({tag, " lo"}, bus.lo_o, exp_lo);
    check({tag, " hi"}, bus.hi_o, exp_hi);
    check({tag, " whilo"}, {31'd0, bus.whilo_o}, 32'd1);
    issue(OP_NOP, SEL_NOP, 32'd0, 32'd0);
  endtask

  initial begin
    bus.aluop_i = OP_ADDU;  bus.alusel_i = SEL_ARITH;
    bus.reg1_i = 32'h1234;  bus.reg2_i = 32'h5678;
    bus.wd_i = 5'd7;        bus.wreg_i = 1'b1;
    bus.link_address_i = 32'h00400008;
    bus.is_in_delayslot_i = 1'b1;
    bus.inst_i = 32'h0000_0010;
    bus.hi_i = 32'h1111_2222; bus.lo_i = 32'h3333_4444;

    @(negedge clk);
    check("rst wdata", bus.wdata_o, 32'd0);
    check("rst wreg", {31'd0, bus.wreg_o}, 32'd0);
    check("rst wd", {27'd0, bus.wd_o}, 32'd0);
    check("rst mem_addr", bus.mem_addr_o, 32'd0);
    check("rst reg2", bus.reg2_o, 32'd0);
    check("rst aluop", {24'd0, bus.aluop_o}, 32'd0);
    check("rst dslot", {31'd0, bus.is_in_delayslot_o}, 32'd0);
    check("rst stall", {31'd0, bus.stallreq_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);
    check("addu wdata", bus.wdata_o, 32'd0);
    check("addu wreg", {31'd0, bus.wreg_o}, 32'd1);
    check("addu wd", {27'd0, bus.wd_o}, 32'd7);
    check("addu dslot", {31'd0, bus.is_in_delayslot_o}, 32'd1);
    check("addu aluop", {24'd0, bus.aluop_o}, {24'd0, OP_ADDU});
    check("addu stall", {31'd0, bus.stallreq_o}, 32'd0);
    issue(OP_ADD, SEL_ARITH, 32'h7FFF_FFFF, 32'd1);
    check("add ovf wreg", {31'd0, bus.wreg_o}, 32'd0);
    issue(OP_ADD, SEL_ARITH, 32'd5, 32'hFFFF_FFFD);
    check("add wdata", bus.wdata_o, 32'd2);
    check("add wreg", {31'd0, bus.wreg_o}, 32'd1);
    issue(OP_SUB, SEL_ARITH, 32'h8000_0000, 32'd1);
    check("sub ovf wreg", {31'd0, bus.wreg_o}, 32'd0);
    issue(OP_SUBU, SEL_ARITH, 32'd3, 32'd5);
    check("subu wdata", bus.wdata_o, 32'hFFFF_FFFE);
    check("subu wreg", {31'd0, bus.wreg_o}, 32'd1);

    issue(OP_AND, SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("and", bus.wdata_o, 32'h00F0_000F);
    issue(OP_OR, SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("or", bus.wdata_o, 32'hFFF0_0FFF);
    issue(OP_XOR, SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("xor", bus.wdata_o, 32'hFF00_0FF0);
    issue(OP_NOR, SEL_LOGIC, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    check("nor", bus.wdata_o, 32'h000F_F000);

    issue(OP_SLL, SEL_SHIFT, 32'd31, 32'd1);
    check("sll", bus.wdata_o, 32'h8000_0000);
    issue(OP_SRL, SEL_SHIFT, 32'd4, 32'h8000_0000);
    check("srl", bus.wdata_o, 32'h0800_0000);
    issue(OP_SRA, SEL_SHIFT, 32'd4, 32'h8000_0000);
    check("sra", bus.wdata_o, 32'hF800_0000);
    issue(OP_SLT, SEL_ARITH, 32'd1, 32'hFFFF_FFFF);
    check("slt", bus.wdata_o, 32'd0);
    issue(OP_SLTU, SEL_ARITH, 32'd1, 32'hFFFF_FFFF);
    check("sltu", bus.wdata_o, 32'd1);

    issue(OP_MFHI, SEL_MOVE, 32'd0, 32'd0);
    check("mfhi", bus.wdata_o, 32'h1111_2222);
    issue(OP_MFLO, SEL_MOVE, 32'd0, 32'd0);
    check("mflo", bus.wdata_o, 32'h3333_4444);
    issue(OP_MTHI, SEL_NOP, 32'hAAAA_5555, 32'd0);
    check("mthi whilo", {31'd0, bus.whilo_o}, 32'd1);
    check("mthi hi", bus.hi_o, 32'hAAAA_5555);
    check("mthi lo", bus.lo_o, 32'h3333_4444);
    issue(OP_MTLO, SEL_NOP, 32'h0BAD_F00D, 32'd0);
    check("mtlo hi", bus.hi_o, 32'h1111_2222);
    check("mtlo lo", bus.lo_o, 32'h0BAD_F00D);

    issue(OP_JAL, SEL_JB, 32'd0, 32'd0);
    check("jal link", bus.wdata_o, 32'h0040_0008);
    bus.inst_i = 32'h8C22_FFFC;
    issue(OP_LW, SEL_LS, 32'h0000_1000, 32'hCAFE_BABE);
    check("lw addr", bus.mem_addr_o, 32'h0000_0FFC);
    check("lw reg2", bus.reg2_o, 32'hCAFE_BABE);
    issue(8'hFF, SEL_NOP, 32'd9, 32'd9);
    check("bad op wdata", bus.wdata_o, 32'd0);
    check("bad op whilo", {31'd0, bus.whilo_o}, 32'd0);

`ifdef EX_DIV_EN
    run_div("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("divu 100/0", OP_DIVU, 32'd100, 32'd0, 1, 32'd0, 32'd0);
    run_div("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 33, 32'd1, 32'h7FFF_FFFE);

    issue(OP_DIV, SEL_NOP, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort stall", {31'd0, bus.stallreq_o}, 32'd0);
    check("abort lo", bus.lo_o, 32'd0);
    check("abort whilo", {31'd0, bus.whilo_o}, 32'd0);
    check("abort wd", {27'd0, bus.wd_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.aluop_i = OP_NOP;
    run_div("divu 9/3", OP_DIVU, 32'd9, 32'd3, 33, 32'd3, 32'd0);
`else
    issue(OP_DIV, SEL_NOP, 32'hFFFF_FFF9, 32'd2);
    check("nodiv stall", {31'd0, bus.stallreq_o}, 32'd0);
    check("nodiv whilo", {31'd0, bus.whilo_o}, 32'd1);
    check("nodiv lo", bus.lo_o, 32'd0);
    check("nodiv hi", bus.hi_o, 32'd0);
    issue(OP_DIVU, SEL_NOP, 32'd100, 32'd0);
    check("nodiv divu stall", {31'd0, bus.stallreq_o}, 32'd0);
    check("nodiv divu whilo", {31'd0, bus.whilo_o}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
